data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised data RAM for the single-cycle RV32 core; serves load/store traffic from the ALU-computed byte address.
- Writes are synchronous on the rising CLK edge. Reads are combinational, so a load completes within the same cycle.
- The whole array clears asynchronously on reset, so every read value is defined from time zero.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, width of the byte address bus A.
- DEPTH, 64, number of DATA_W-bit words; must be a power of two, >= 2.

Ports:
- CLK  input  1  system clock; writes on rising edge.
- RST  input  1  asynchronous, active-high reset; clears every memory word to 0.
- WE   input  1  write enable, sampled on rising CLK.
- A    input  ADDR_W  byte address; word index = A[log2(DEPTH)+1:2].
- WD   input  DATA_W  write data.
- RD   output DATA_W  read data = mem[word index of A], combinational.

Behaviour:
- Storage: DEPTH words of DATA_W bits, implemented as resettable registers. No RAM macro is used, because an asynchronous clear is required.
- Index: idx = A[log2(DEPTH)+1:2].
  - A[1:0] are ignored, so addresses 4k..4k+3 alias to word k.
  - Bits above log2(DEPTH)+1 are ignored, so the address wraps modulo DEPTH*4 bytes.
- Reset:
  - While RST=1, all words are 0 and RD=0 for any A.
  - The clear takes effect immediately, with no clock needed.
  - Writes are blocked while RST is high.
- Write:
  - On rising CLK with RST=0 and WE=1, mem[idx] <= WD (full word).
  - WE=0 leaves contents unchanged.
- Read:
  - RD = mem[idx] combinationally, with zero-cycle latency.
  - RD tracks A changes within the cycle and is independent of WE.
- Read-during-write, same word: before the edge RD shows the old value; after the edge RD shows WD. There is no bypass.
- Reset asserted mid-operation: a write on the same edge that RST rises is discarded. Memory is all-zero after RST deasserts.
- RST deassertion: the first write can occur on the first rising CLK edge after RST falls.
- No X outputs: RD is defined for every A value once reset has been applied.
- No misalignment trap; alignment checking belongs to the core's load/store unit.

Decomposition:
- Shared package holds:
  - XLEN = 32, the default for DATA_W and ADDR_W.
  - DMEM_DEPTH = 64.
  - A function/constant for the index width, log2(DMEM_DEPTH).
- No sub-module. One always block handles async reset and write; one continuous assignment produces RD.

Test Plan:
- Reset: pulse RST=1 asynchronously between clock edges, with WE=0; sweep A=0,4,...,252 -> RD=0 for every word, immediately, before any CLK edge.
- Sequential writes:
  - Stimulus: WE=1, A=i, WD=i+3 for i=0..9, one CLK period each. Then WE=0 and read A=0..9.
  - Required: RD=6 for A=0..3, RD=10 for A=4..7, RD=12 for A=8..9. This shows byte-address aliasing with last write winning.
- Aligned word writes:
  - Stimulus: write A=4k, WD=k+3 for k=0..9.
  - Required: reading A=4k returns k+3; word 10 (A=40) returns 0.
- Read-during-write:
  - Stimulus: A=8 holds 0x11111111; set WE=1, WD=0xDEADBEEF.
  - Required: RD=0x11111111 before the edge, 0xDEADBEEF after it.
- Wrap and WE gating:
  - Write A=0x100 (DEPTH=64) with 0xCAFEF00D -> RD at A=0 reads 0xCAFEF00D.
  - With WE=0 and WD toggling over 3 edges -> no word changes.
- Mid-operation reset:
  - Fill words 0..3, then raise RST on the same edge as a write to A=12, WD=0xA5A5A5A5.
  - Required: all words read 0 after RST releases.
  - Then write A=12, WD=0x12345678 on the next edge -> RD at A=12 is 0x12345678.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared constants for the RV32 data memory: machine word width, depth and index width.
package data_memory_pkg;

   localparam int XLEN       = 32;
   localparam int DMEM_DEPTH = 64;

   // Word-index width for a power-of-two depth.
   function automatic int idx_width(input int depth);
      return $clog2(depth);
   endfunction

   localparam int DMEM_IDX_W = idx_width(DMEM_DEPTH);

endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the core (master) and the data memory (slave).
interface data_memory_if
   import data_memory_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = XLEN
);

   logic              we;
   logic [ADDR_W-1:0] a;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] rd;

   modport master (output we, output a, output wd, input rd);
   modport slave  (input we, input a, input wd, output rd);

endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM: synchronous full-word writes, combinational reads,
// whole array cleared asynchronously by rst.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = XLEN,
   parameter int DEPTH  = DMEM_DEPTH
)(
   input logic          clk,
   input logic          rst,
   data_memory_if.slave bus
);

   localparam int IDX_W = idx_width(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [IDX_W-1:0]  idx_s;
   logic              unused_addr_s;

   // Byte offset and bits above the array size are dropped, so addresses alias and wrap.
   assign idx_s         = bus.a[IDX_W+1:2];
   assign unused_addr_s = ^{bus.a[1:0], bus.a[ADDR_W-1:IDX_W+2]};

   // Registers rather than a RAM macro, since the clear must be asynchronous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (bus.we) begin
         mem_r[idx_s] <= bus.wd;
      end
   end

   assign bus.rd = mem_r[idx_s];

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected read values into a
// scoreboard queue and a separate monitor samples rd and compares.
module tb_data_memory;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_entry_t;

   logic clk;
   logic rst;
   logic clk_run;
   int   n_vec;
   int   n_err;

   sb_entry_t sb_q[$];

   data_memory_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   data_memory dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Clock held low until the pre-clock reset checks are done.
   initial begin
      clk = 1'b0;
      wait (clk_run);
      forever #5 clk = ~clk;
   end

   // Monitor: rd is combinational, so it is valid 1 ns after stimulus queues an expectation.
   initial begin
      sb_entry_t e;
      n_vec = 0;
      n_err = 0;
      forever begin
         wait (sb_q.size() != 0);
         #1;
         e = sb_q.pop_front();
         n_vec++;
         if (bus.rd !== e.exp) begin
            n_err++;
            $display("FAIL %s: rd=%h expected %h (a=%h t=%0t)", e.name, bus.rd, e.exp, bus.a, $time);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] exp);
      sb_entry_t e;
      e.name = nm;
      e.exp  = exp;
      sb_q.push_back(e);
      #2;
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] addr, input logic [31:0] exp);
      bus.a = addr;
      chk(nm, exp);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.we = 1'b1;
      bus.a  = addr;
      bus.wd = data;
      @(posedge clk);
      @(negedge clk);
      bus.we = 1'b0;
   endtask

   initial begin
      clk_run = 1'b0;
      rst     = 1'b0;
      bus.we  = 1'b0;
      bus.a   = 32'd0;
      bus.wd  = 32'd0;

      // Asynchronous clear with no clock running
      #2;
      rst = 1'b1;
      rd_chk("rst_immediate", 32'd0, 32'd0);
      for (int i = 0; i < 64; i++) begin
         rd_chk("rst_sweep", 32'(i * 4), 32'd0);
      end
      rst = 1'b0;
      rd_chk("rst_released", 32'd252, 32'd0);
      clk_run = 1'b1;

      // Sequential byte addresses alias onto words; last write wins
      for (int i = 0; i < 10; i++) begin
         wr(32'(i), 32'(i + 3));
      end
      for (int i = 0; i < 10; i++) begin
         rd_chk("seq_alias", 32'(i), (i < 4) ? 32'd6 : ((i < 8) ? 32'd10 : 32'd12));
      end

      // Aligned word writes
      for (int k = 0; k < 10; k++) begin
         wr(32'(4 * k), 32'(k + 3));
      end
      for (int k = 0; k < 10; k++) begin
         rd_chk("aligned", 32'(4 * k), 32'(k + 3));
      end
      rd_chk("untouched_w10", 32'd40, 32'd0);

      // Read-during-write: old value before the edge, new value after, no bypass
      wr(32'd8, 32'h1111_1111);
      @(negedge clk);
      bus.we = 1'b1;
      bus.a  = 32'd8;
      bus.wd = 32'hDEAD_BEEF;
      chk("rdw_before", 32'h1111_1111);
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      chk("rdw_after", 32'hDEAD_BEEF);

      // Address wrap modulo DEPTH*4 bytes
      wr(32'h0000_0100, 32'hCAFE_F00D);
      rd_chk("wrap_a0", 32'd0, 32'hCAFE_F00D);
      rd_chk("wrap_alias", 32'h0000_0103, 32'hCAFE_F00D);
      rd_chk("wrap_w1_kept", 32'd4, 32'd4);

      // WE low: toggling WD across edges changes nothing
      @(negedge clk);
      bus.we = 1'b0;
      bus.a  = 32'd20;
      for (int n = 0; n < 3; n++) begin
         bus.wd = (n % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
         @(posedge clk);
         @(negedge clk);
         chk("we_gate_w5", 32'd8);
      end
      rd_chk("we_gate_w0", 32'd0, 32'hCAFE_F00D);
      rd_chk("we_gate_w9", 32'd36, 32'd12);

      // Reset rising on the same edge as a write
      for (int k = 0; k < 4; k++) begin
         wr(32'(4 * k), 32'h100 + 32'(k));
      end
      rd_chk("fill_w3", 32'd12, 32'h0000_0103);
      @(negedge clk);
      bus.we = 1'b1;
      bus.a  = 32'd12;
      bus.wd = 32'hA5A5_A5A5;
      @(posedge clk);
      rst = 1'b1;
      #1;
      chk("rst_same_edge", 32'd0);
      @(posedge clk);
      #1;
      chk("rst_blocks_write", 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      bus.we = 1'b0;
      for (int k = 0; k < 11; k++) begin
         rd_chk("post_rst_zero", 32'(4 * k), 32'd0);
      end

      // First write after release lands on the next edge
      @(negedge clk);
      bus.we = 1'b1;
      bus.a  = 32'd12;
      bus.wd = 32'h1234_5678;
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      chk("first_write_after_rst", 32'h1234_5678);
      rd_chk("neighbour_w2", 32'd8, 32'd0);

      // Drain the scoreboard with a bound
      for (int t = 0; t < 100 && sb_q.size() != 0; t++) begin
         #1;
      end
      #2;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: %0d entries pending, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
